// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-cathode 7-segment display.
// Double-buffered digits, per-slot dead time, leading-zero and invalid-code blanking.
module seven_seg_scan_ctrl #(
  parameter int N_DIGITS    = 4,
  parameter int SCAN_DIV    = 100000,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   bcd_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic                    lz_en,
  output logic [3:0]              bcd_out,
  output logic                    dp_out,
  output logic [N_DIGITS-1:0]     digit_en,
  output logic                    frame_tick,
  output logic                    bcd_err
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, DEAD, ON} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*N_DIGITS-1:0]   shadow_bcd, active_bcd;
  logic [N_DIGITS-1:0]     shadow_dp, active_dp;
  logic                    slot_blank;

  logic                    slot_end, wrap, reload;
  logic [4*N_DIGITS-1:0]   src_bcd;
  logic [N_DIGITS-1:0]     src_dp;
  logic [IW-1:0]           nxt_idx;
  logic [3:0]              nxt_digit;
  logic                    nxt_blank, nxt_dp;

  function automatic logic [3:0] digit_of(input logic [4*N_DIGITS-1:0] b, input int i);
    return b[4*i +: 4];
  endfunction

  function automatic logic any_invalid(input logic [4*N_DIGITS-1:0] b);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_DIGITS; i++)
      if (b[4*i +: 4] > 4'd9) r = 1'b1;
    return r;
  endfunction

  // A digit is dark for its whole slot if it is not BCD, or if it and every
  // more-significant digit are zero; the rightmost digit always shows.
  function automatic logic blank_of(input logic [4*N_DIGITS-1:0] b, input int i, input logic lz);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int j = 0; j < N_DIGITS; j++)
      if (j >= i && b[4*j +: 4] != 4'd0) upper_zero = 1'b0;
    return (digit_of(b, i) > 4'd9) || (lz && i != 0 && upper_zero);
  endfunction

  // NOTE: every signal here is assigned on every path, so no latch is inferred.
  always_comb begin
    slot_end  = (state == ON) && (cnt == CW'(SCAN_DIV - 1));
    wrap      = slot_end && (idx == IW'(N_DIGITS - 1));
    reload    = (state == IDLE) || wrap;
    src_bcd   = reload ? shadow_bcd : active_bcd;
    src_dp    = reload ? shadow_dp  : active_dp;
    nxt_idx   = reload ? '0 : idx + IW'(1);
    nxt_digit = digit_of(src_bcd, int'(nxt_idx));
    nxt_blank = blank_of(src_bcd, int'(nxt_idx), lz_en);
    nxt_dp    = src_dp[nxt_idx] & ~nxt_blank;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; this is what makes a load on the wrap edge defer.
  // The digit buffers are small register banks, so they take the reset too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shadow_bcd <= '0;
      shadow_dp  <= '0;
      active_bcd <= '0;
      active_dp  <= '0;
      slot_blank <= 1'b0;
      bcd_out    <= '0;
      dp_out     <= 1'b0;
      digit_en   <= '0;
      frame_tick <= 1'b0;
      bcd_err    <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (load) begin
        shadow_bcd <= bcd_in;
        shadow_dp  <= dp_in;
      end
      if (!en) begin
        state    <= IDLE;
        cnt      <= '0;
        idx      <= '0;
        digit_en <= '0;
        dp_out   <= 1'b0;
      end else if (state == IDLE || slot_end) begin
        // Start of a slot: dark, but the next digit's code is already on the bus.
        state      <= DEAD;
        cnt        <= '0;
        idx        <= nxt_idx;
        digit_en   <= '0;
        bcd_out    <= nxt_digit;
        dp_out     <= nxt_dp;
        slot_blank <= nxt_blank;
        frame_tick <= wrap;
        if (reload) begin
          active_bcd <= src_bcd;
          active_dp  <= src_dp;
          bcd_err    <= any_invalid(src_bcd);
        end
      end else begin
        cnt <= cnt + CW'(1);
        if (state == DEAD && cnt == CW'(DEAD_CYCLES - 1)) begin
          state    <= ON;
          digit_en <= slot_blank ? '0 : (N_DIGITS'(1) << idx);
        end
      end
    end
  end

endmodule
